// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multichannel PWM block.
//   pwm_mode_e  : counting mode (edge-aligned or center-aligned)
//   cnt_max()   : largest counter/duty value for a given resolution
//   duty_idx_w(): width of the duty channel index for a given channel count
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    // All-ones value of a CNT_W-bit counter. Duty equal to this is "always on".
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // A single channel still needs a one-bit index so the port exists.
    function automatic int duty_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// ---------------------------------------------------------------------------
// pwm_timebase
// Shared period generator for all PWM channels: prescaler, edge/center
// up-down counter, mode latch and period boundary detection.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   center_mode  : requested mode, sampled only at a period boundary
//   prescale     : counter advances once per (prescale+1) clocks
//   cnt          : current period counter value
//   wrap         : combinational, high in the cycle whose edge returns cnt
//                  to 0 (the boundary); used to load the active duty values
//   period_tick  : registered, high for the one cycle in which cnt is 0
//                  right after a boundary
// ---------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               center_mode,
    input  logic [PRESC_W-1:0] prescale,
    output logic [CNT_W-1:0]   cnt,
    output logic               wrap,
    output logic               period_tick
);

    localparam int              MAX_VAL = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0] TOP    = CNT_W'(MAX_VAL - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_lim_q;
    logic [PRESC_W-1:0] presc_lim;
    logic               adv;
    logic               dir_up;
    pwm_mode_e          mode;

    // The prescale limit is captured at the start of each prescaler window,
    // so a new prescale value only takes effect once the current window has
    // wrapped. In the first cycle of a window the live input is used so the
    // new value applies immediately after the wrap.
    always_comb begin
        presc_lim = presc_lim_q;
        if (presc_cnt == '0) begin
            presc_lim = prescale;
        end
        adv = (presc_cnt == presc_lim);
    end

    // Boundary detection: edge mode wraps after MAX-1, center mode wraps
    // when counting down from 1. Either way the next cnt value is 0.
    always_comb begin
        wrap = 1'b0;
        if (adv) begin
            if (mode == MODE_EDGE) begin
                wrap = (cnt == TOP);
            end else begin
                wrap = !dir_up && (cnt == ONE);
            end
        end
    end

    // Prescaler: counts 0..limit, returns to 0 on the advance cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt   <= '0;
            presc_lim_q <= '0;
        end else begin
            if (presc_cnt == '0) begin
                presc_lim_q <= prescale;
            end
            if (adv) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // Period counter. At a boundary the mode is re-latched and the
    // direction forced up, so a mode change never lands mid-period. In
    // center mode the counter turns around at MAX-1 and counts down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dir_up      <= 1'b1;
            mode        <= MODE_EDGE;
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
            if (wrap) begin
                cnt    <= '0;
                dir_up <= 1'b1;
                mode   <= pwm_mode_e'(center_mode);
            end else if (adv) begin
                if (mode == MODE_CENTER && !dir_up) begin
                    cnt <= cnt - 1'b1;
                end else if (mode == MODE_CENTER && cnt == TOP) begin
                    dir_up <= 1'b0;
                    cnt    <= cnt - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// ---------------------------------------------------------------------------
// pwm_multichannel
// NUM_CH PWM outputs driven from one shared timebase, with double-buffered
// per-channel duty registers that only take effect at a period boundary.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   out_en       : per-channel output enable (0 forces the pin low)
//   pwm_en       : per-channel PWM enable (0 = static high when enabled)
//   center_mode  : 0 edge-aligned, 1 center-aligned (applied at boundary)
//   prescale     : counter advances once per (prescale+1) clocks
//   duty_we      : single-cycle duty write strobe
//   duty_ch      : channel index of the write; indices >= NUM_CH ignored
//   duty_data    : new duty value, written to the pending register
//   out          : registered PWM outputs
//   period_tick  : one-cycle pulse at each period boundary
// ---------------------------------------------------------------------------
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             out_en,
    input  logic [NUM_CH-1:0]             pwm_en,
    input  logic                          center_mode,
    input  logic [PRESC_W-1:0]            prescale,
    input  logic                          duty_we,
    input  logic [duty_idx_w(NUM_CH)-1:0] duty_ch,
    input  logic [CNT_W-1:0]              duty_data,
    output logic [NUM_CH-1:0]             out,
    output logic                          period_tick
);

    localparam int IDX_W = duty_idx_w(NUM_CH);

    logic [CNT_W-1:0]  cnt;
    logic              wrap;
    logic [NUM_CH-1:0] out_next;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .center_mode (center_mode),
        .prescale    (prescale),
        .cnt         (cnt),
        .wrap        (wrap),
        .period_tick (period_tick)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] pending_duty;
        logic [CNT_W-1:0] active_duty;

        // Duty double buffer. Each slice decodes its own index, so an
        // out-of-range index simply matches no slice. On a boundary the
        // active copy takes the pending value from before any same-cycle
        // write, which then waits for the following boundary.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pending_duty <= '0;
                active_duty  <= '0;
            end else begin
                if (duty_we && duty_ch == IDX_W'(i)) begin
                    pending_duty <= duty_data;
                end
                if (wrap) begin
                    active_duty <= pending_duty;
                end
            end
        end

        // cnt never exceeds MAX-1, so duty 0 is always low and duty MAX
        // is always high without special cases.
        assign out_next[i] = out_en[i] & (pwm_en[i] ? (cnt < active_duty) : 1'b1);
    end

    // Output register: one clock from counter/enable change to the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// ---------------------------------------------------------------------------
// tb_pwm_multichannel
// Self-checking bench for pwm_multichannel (NUM_CH=12, CNT_W=8). A cycle
// reference model built on "advances since the last boundary" predicts
// out and period_tick every clock; directed steps check reset, latencies,
// high times, shadow updates, enables, invalid writes and center mode,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_pwm_multichannel;

    localparam int NCH = 12;
    localparam int MAXV = 255;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  out_en;
    logic [NCH-1:0]  pwm_en;
    logic            center_mode;
    logic [7:0]      prescale;
    logic            duty_we;
    logic [3:0]      duty_ch;
    logic [7:0]      duty_data;
    logic [NCH-1:0]  out;
    logic            period_tick;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_p, m_lim, m_phase;
    bit m_mode;
    int m_pend [NCH];
    int m_act  [NCH];

    pwm_multichannel #(
        .NUM_CH  (NCH),
        .CNT_W   (8),
        .PRESC_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .out_en      (out_en),
        .pwm_en      (pwm_en),
        .center_mode (center_mode),
        .prescale    (prescale),
        .duty_we     (duty_we),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
        .out         (out),
        .period_tick (period_tick)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Compare one observed value against the model's expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int periodLen(input bit mode);
        return mode ? 2 * (MAXV - 1) : MAXV;
    endfunction

    // Counter value as a function of advances since the boundary
    function automatic int cntOf(input int phase, input bit mode);
        if (!mode) return phase;
        return (phase < MAXV) ? phase : 2 * (MAXV - 1) - phase;
    endfunction

    function automatic bit nextIsBoundary();
        int l;
        l = (m_p == 0) ? int'(prescale) : m_lim;
        return (m_p == l) && (((m_phase + 1) % periodLen(m_mode)) == 0);
    endfunction

    task automatic modelReset();
        m_p = 0; m_lim = 0; m_phase = 0; m_mode = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
    endtask

    // Advance one clock: predict, clock the DUT, then check
    task automatic applyStimulus();
        logic [NCH-1:0] eo;
        bit adv, bnd;
        int c;
        c = cntOf(m_phase, m_mode);
        for (int i = 0; i < NCH; i++)
            eo[i] = out_en[i] & (pwm_en[i] ? (c < m_act[i]) : 1'b1);
        if (m_p == 0) m_lim = int'(prescale);
        adv = (m_p == m_lim);
        m_p = adv ? 0 : m_p + 1;
        bnd = 1'b0;
        if (adv) begin
            m_phase = (m_phase + 1) % periodLen(m_mode);
            bnd = (m_phase == 0);
        end
        if (bnd) begin
            for (int i = 0; i < NCH; i++) m_act[i] = m_pend[i];
            m_mode = center_mode;
        end
        if (duty_we && duty_ch < 4'd12) m_pend[duty_ch] = int'(duty_data);
        @(posedge clk);
        #1;
        checkOutput("out", 32'(out), 32'(eo));
        checkOutput("period_tick", 32'(period_tick), 32'(bnd));
    endtask

    task automatic writeDuty(input logic [3:0] ch, input logic [7:0] val);
        duty_we = 1'b1; duty_ch = ch; duty_data = val;
        applyStimulus();
        duty_we = 1'b0;
    endtask

    // Step until period_tick, bounded; returns the number of steps taken
    task automatic waitTick(input int limit, output int n);
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!period_tick && n < limit);
        if (!period_tick) checkOutput("tick_timeout", 32'(period_tick), 32'd1);
    endtask

    // Step n cycles, counting high cycles of out[ch]
    task automatic countHigh(input int n, input int ch, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            applyStimulus();
            hi += int'(out[ch]);
        end
    endtask

    initial begin
        int n, hi;
        rst_n = 1'b0; out_en = '1; pwm_en = '1; center_mode = 1'b0;
        prescale = 8'd0; duty_we = 1'b0; duty_ch = '0; duty_data = '0;
        modelReset();

        // Reset held with all enables set
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", 32'(out), 32'd0);
        checkOutput("reset_tick", 32'(period_tick), 32'd0);
        rst_n = 1'b1;

        // First boundary one full edge period after release
        waitTick(400, n);
        checkOutput("first_tick_latency", 32'(n), 32'd255);

        // Edge-mode duties 0x40 / 0x00 / 0xFF
        writeDuty(4'd0, 8'h40);
        writeDuty(4'd1, 8'h00);
        writeDuty(4'd2, 8'hFF);
        writeDuty(4'd5, 8'hFF);
        waitTick(400, n);
        countHigh(255, 0, hi);
        checkOutput("edge_high_0x40", 32'(hi), 32'd64);
        checkOutput("period_tick_at_end", 32'(period_tick), 32'd1);
        countHigh(255, 1, hi);
        checkOutput("edge_high_0x00", 32'(hi), 32'd0);
        countHigh(255, 2, hi);
        checkOutput("edge_high_0xFF", 32'(hi), 32'd255);

        // Shadow update mid-period, then a write in the boundary cycle
        repeat (100) applyStimulus();
        writeDuty(4'd3, 8'h80);
        waitTick(400, n);
        countHigh(255, 3, hi);
        checkOutput("shadow_mid_period", 32'(hi), 32'd128);
        n = 0;
        while (!nextIsBoundary() && n < 400) begin
            applyStimulus();
            n++;
        end
        writeDuty(4'd3, 8'h20);
        countHigh(255, 3, hi);
        checkOutput("shadow_boundary_old", 32'(hi), 32'd128);
        countHigh(255, 3, hi);
        checkOutput("shadow_boundary_new", 32'(hi), 32'd32);

        // Enables: static high, then forced low despite duty
        pwm_en[5] = 1'b0;
        applyStimulus();
        checkOutput("en_static_high", 32'(out[5]), 32'd1);
        out_en[5] = 1'b0;
        applyStimulus();
        checkOutput("en_forced_low", 32'(out[5]), 32'd0);
        pwm_en[5] = 1'b1;
        repeat (10) applyStimulus();
        checkOutput("en_forced_low_pwm", 32'(out[5]), 32'd0);
        out_en[5] = 1'b1;

        // Invalid index writes must change no waveform over two periods
        writeDuty(4'd13, 8'hAA);
        writeDuty(4'd12, 8'h11);
        writeDuty(4'd15, 8'hFF);
        repeat (2 * 255 + 5) applyStimulus();

        // Prescale 3, center mode, duty 0x80 on ch0
        writeDuty(4'd0, 8'h80);
        repeat (37) applyStimulus();
        prescale = 8'd3;
        center_mode = 1'b1;
        waitTick(3000, n);
        waitTick(3000, n);
        waitTick(3000, n);
        countHigh(2032, 0, hi);
        checkOutput("center_high_0x80", 32'(hi), 32'd1020);
        checkOutput("center_period_end", 32'(period_tick), 32'd1);
        waitTick(3000, n);
        checkOutput("center_period_len", 32'(n), 32'd2032);

        // Randomized phase
        for (int k = 0; k < 3000; k++) begin
            duty_we   = ($urandom_range(0, 3) == 0);
            duty_ch   = 4'($urandom_range(0, 15));
            duty_data = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                out_en      = NCH'($urandom);
                pwm_en      = NCH'($urandom);
                prescale    = 8'($urandom_range(0, 2));
                center_mode = 1'($urandom);
            end
            applyStimulus();
        end
        duty_we = 1'b0;

        // Reset mid-period: outputs drop immediately, then restart
        out_en = '1; pwm_en = '1; pwm_en[4] = 1'b0;
        repeat (20) applyStimulus();
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", 32'(out), 32'd0);
        checkOutput("async_reset_tick", 32'(period_tick), 32'd0);
        prescale = 8'd0; center_mode = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        rst_n = 1'b1;
        waitTick(400, n);
        checkOutput("restart_tick_latency", 32'(n), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised successor to the 16-channel, 8-bit PWM peripheral. Generates NUM_CH PWM outputs from one shared period counter with CNT_W-bit resolution, a programmable clock prescaler, edge- or center-aligned mode, and per-channel duty registers. Duty registers are double-buffered so updates take effect only at a period boundary, with no glitches. It sits between the SPI register file, which drives the enable masks and duty writes, and the chip output pins.

## Interface
Parameters:
- NUM_CH, 16, number of PWM channels (1..32)
- CNT_W, 8, counter/duty resolution in bits (4..16); MAX = 2^CNT_W − 1
- PRESC_W, 8, prescaler width

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- out_en  input  NUM_CH  per-channel output enable
- pwm_en  input  NUM_CH  per-channel PWM enable (0 = static high when out_en=1)
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned
- prescale  input  PRESC_W  counter advances once per (prescale+1) clk cycles
- duty_we  input  1  single-cycle duty write strobe
- duty_ch  input  $clog2(NUM_CH)  channel index for write; index ≥ NUM_CH ignored
- duty_data  input  CNT_W  duty value
- out  output  NUM_CH  registered PWM outputs
- period_tick  output  1  one-cycle pulse at each period boundary

## Operation
- Prescaler: counts 0..prescale; emits adv when it equals prescale, then returns to 0. prescale=0 → adv every cycle. A prescale change takes effect on the next prescaler wrap.
- Edge mode: cnt counts 0..MAX−1 on adv, wraps to 0. Period = MAX advances.
- Center mode: cnt counts up 0..MAX−1, then down to 1, then 0 again. Period = 2·(MAX−1) advances. Direction flips at the extremes.
- Boundary: the adv cycle on which cnt becomes 0. At a boundary:
  - active_duty[i] ← pending_duty[i] for all channels
  - latched mode ← center_mode; direction ← up
- Compare: raw[i] = (cnt < active_duty[i]).
  - duty=0 → always low
  - duty=MAX → always high
  - edge mode: high time = duty advances
- Output: out[i] ← out_en[i] & (pwm_en[i] ? raw[i] : 1).
- Duty write: duty_we=1 with a valid duty_ch → pending_duty[duty_ch] ← duty_data. Invalid channels are ignored, with no side effects.
- Write coincident with a boundary: active takes the old pending value; the new value applies at the following boundary.
- Reset values:
  - prescaler=0, cnt=0, direction=up, latched mode=edge
  - all pending/active duty=0
  - out=0, period_tick=0
- Reset mid-period: outputs go to 0 immediately (asynchronous). After release, counting restarts from cnt=0, with the first boundary one full period later.

## Timing
- out is registered: 1 clk after the cnt/enable change that causes it.
- out_en/pwm_en changes reach out in 1 clk, independent of the boundary.
- period_tick asserts in the same cycle that cnt is first 0 at a boundary, for exactly 1 clk. It asserts on every boundary, including prescaled ones.
- New duty values: visible on out no earlier than 1 clk after the next boundary, and no later than 1 period + 1 clk after the write.
- No back-pressure: one duty write per cycle is accepted.

## Structure
- Shared package pwm_pkg:
  - mode constants MODE_EDGE/MODE_CENTER
  - CNT_MAX function of CNT_W
  - duty index width helper
- Sub-module pwm_timebase: prescaler, up/down counter, boundary/period_tick generation, mode latch.
- Top: generates NUM_CH compare/enable/output slices plus the duty register arrays.

## Test plan
- Reset: hold rst_n=0 with all enables=1 → out=0, period_tick=0. Release → first period_tick after 255 clk (CNT_W=8, prescale=0, edge).
- Edge duty: ch0 duty=0x40, out_en=pwm_en=1, prescale=0 → out[0] high for 64 clk of every 255-clk period. Duty 0x00 → constant 0; 0xFF → constant 1.
- Shadow update: write ch3 duty 0x80 mid-period → out[3] unchanged until the next period_tick, then 128/255. Repeat with the write in the boundary cycle → applies one period later.
- Prescale/center: prescale=3, center_mode=1, duty=0x80 → period 2·254·4 = 2032 clk, high pulse centered on cnt=0. A mode change mid-period applies only at the boundary.
- Enables: out_en[5]=1, pwm_en[5]=0 → out[5]=1 after 1 clk. out_en[5]=0 → out[5]=0 regardless of duty.
- Invalid index: NUM_CH=12, duty_ch=13 write → no channel's out waveform changes over 2 periods.
